ops_scheduler: RTL and testbench

//  Issue/collect controller in front of the posit ops datapath. Accepts tagged requests (op + 3 FIRs)

---
 rtl/ppu_pkg.sv | 52 +++++
 rtl/ops_result_fifo.sv | 57 +++++
 rtl/ops_scheduler.sv | 134 +++++++++++++
 tb/tb_ops_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared posit-unit types: operations, FIR operands, ops result metadata and scheduler entries.
// Also holds the per-operation latency table used by the issue scheduler.
package ppu_pkg;

  localparam int unsigned PPU_N       = 16;
  localparam int unsigned SCALE_W     = 7;
  localparam int unsigned FRAC_W      = 2 * PPU_N;
  localparam int unsigned SCHED_TAG_W = 4;
  localparam int unsigned MAX_OP_LAT  = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_FMA = 3'd3,
    OP_DIV = 3'd4
  } operation_e;

  typedef struct packed {
    logic               nar;
    logic               zero;
    logic               sign;
    logic [SCALE_W-1:0] scale;
    logic [PPU_N-1:0]   mant;
  } fir_t;

  typedef struct packed {
    logic               nar;
    logic               zero;
    logic               sign;
    logic [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]  frac;
    logic               sticky;
  } ops_out_meta_t;

  typedef struct packed {
    logic [SCHED_TAG_W-1:0] tag;
    ops_out_meta_t          result;
  } sched_entry_t;

  // Fixed pipeline depth of each operation inside the ops datapath.
  function automatic int unsigned op_latency(input operation_e op);
    case (op)
      OP_ADD, OP_SUB: return 1;
      OP_MUL:         return 2;
      OP_FMA:         return 3;
      OP_DIV:         return 4;
      default:        return MAX_OP_LAT;
    endcase
  endfunction

endpackage

// File: rtl/ops_result_fifo.sv
// First-word-fall-through result FIFO; the head is read straight from registered storage.
// Pointers wrap naturally because DEPTH is a power of two.
module ops_result_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned W     = $bits(sched_entry_t),
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by r_cnt.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign valid_o = (r_cnt != '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign cnt_o   = r_cnt;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push_i && !pop_i && (r_cnt == CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(pop_i && (r_cnt == '0)));

endmodule

// File: rtl/ops_scheduler.sv
// Issue/collect controller for the posit ops datapath: reserves the completion slot of each op,
// captures ops_result_i when the slot comes due and returns {tag,result} in completion order.
module ops_scheduler
  import ppu_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned MAX_LAT   = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  operation_e         in_op_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  input  fir_t               in_fir1_i,
  input  fir_t               in_fir2_i,
  input  fir_t               in_fir3_i,
  output operation_e         ops_op_o,
  output fir_t               ops_fir1_o,
  output fir_t               ops_fir2_o,
  output fir_t               ops_fir3_o,
  output logic               ops_issue_o,
  input  ops_out_meta_t      ops_result_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [TAG_W-1:0]   out_tag_o,
  output ops_out_meta_t      out_result_o,
  output logic               busy_o
);

  localparam int unsigned LAT_W  = $clog2(MAX_LAT + 1);
  localparam int unsigned INF_W  = $clog2(MAX_LAT + 1);
  localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned CRED_W = $clog2(MAX_LAT + OUT_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    ops_out_meta_t    result;
  } entry_t;

  logic [MAX_LAT:1]  r_resv;
  logic [MAX_LAT:1]  w_resv_nxt;
  logic [TAG_W-1:0]  r_tag     [MAX_LAT:1];
  logic [TAG_W-1:0]  w_tag_nxt [MAX_LAT:1];
  logic [LAT_W-1:0]  w_lat;
  logic              w_coll;
  logic [INF_W-1:0]  w_inflight;
  logic [CRED_W-1:0] w_credit;
  logic              w_issue;
  logic              w_pop;
  logic [CNT_W-1:0]  w_fifo_cnt;
  entry_t            w_push_entry;
  entry_t            w_head;

  assign ops_op_o   = in_op_i;
  assign ops_fir1_o = in_fir1_i;
  assign ops_fir2_o = in_fir2_i;
  assign ops_fir3_o = in_fir3_i;

  assign w_lat = LAT_W'(op_latency(in_op_i));

  // An op of latency L lands in slot L after the shift, which is occupied iff slot L+1 is busy now.
  always_comb begin
    w_coll     = 1'b0;
    w_inflight = '0;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (w_lat == LAT_W'(k)) w_coll = r_resv[k+1];
    end
    for (int k = 1; k <= MAX_LAT; k++) begin
      w_inflight = w_inflight + INF_W'(r_resv[k]);
    end
  end

  // Every in-flight op already owns a FIFO entry, so a capture can never meet a full FIFO.
  assign w_credit    = CRED_W'(w_inflight) + CRED_W'(w_fifo_cnt);
  assign in_ready_o  = rst_i & ~w_coll & (w_credit < CRED_W'(OUT_DEPTH));
  assign w_issue     = in_valid_i & in_ready_o;
  assign ops_issue_o = w_issue;

  always_comb begin
    w_resv_nxt = '0;
    for (int k = 1; k <= MAX_LAT; k++) w_tag_nxt[k] = r_tag[k];
    for (int k = 1; k < MAX_LAT; k++) begin
      w_resv_nxt[k] = r_resv[k+1];
      w_tag_nxt[k]  = r_tag[k+1];
    end
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (w_issue && (w_lat == LAT_W'(k))) begin
        w_resv_nxt[k] = 1'b1;
        w_tag_nxt[k]  = in_tag_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_resv <= '0;
      for (int k = 1; k <= MAX_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_resv <= w_resv_nxt;
      for (int k = 1; k <= MAX_LAT; k++) r_tag[k] <= w_tag_nxt[k];
    end
  end

  assign w_push_entry = '{tag: r_tag[1], result: ops_result_i};
  assign w_pop        = out_valid_o & out_ready_i;

  ops_result_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (r_resv[1]),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .valid_o     (out_valid_o),
    .head_o      (w_head),
    .cnt_o       (w_fifo_cnt)
  );

  assign out_tag_o    = w_head.tag;
  assign out_result_o = w_head.result;
  assign busy_o       = (|r_resv) | (w_fifo_cnt != '0);

  a_pkg_width: assert property (@(posedge clk_i) N == PPU_N);
  a_lat_range: assert property (@(posedge clk_i) disable iff (!rst_i)
    in_valid_i |-> (op_latency(in_op_i) <= MAX_LAT));
  a_issue_free: assert property (@(posedge clk_i) disable iff (!rst_i)
    ops_issue_o |-> !w_coll);

endmodule

// File: tb/tb_ops_scheduler.sv
// Bench for ops_scheduler: directed scenarios plus random traffic against a completion-time model.
module tb_ops_scheduler;
  import ppu_pkg::*;

  localparam int unsigned TAG_W     = 4;
  localparam int unsigned MAX_LAT   = 8;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned RES_W     = $bits(ops_out_meta_t);
  localparam int unsigned FIR_W     = $bits(fir_t);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  operation_e       in_op;
  logic [TAG_W-1:0] in_tag;
  fir_t             fir1, fir2, fir3;
  operation_e       ops_op;
  fir_t             ops_fir1, ops_fir2, ops_fir3;
  logic             ops_issue;
  ops_out_meta_t    ops_result;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  ops_out_meta_t    out_result;
  logic             busy;

  ops_scheduler #(.N(16), .TAG_W(TAG_W), .MAX_LAT(MAX_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_tag_i(in_tag),
    .in_fir1_i(fir1), .in_fir2_i(fir2), .in_fir3_i(fir3),
    .ops_op_o(ops_op), .ops_fir1_o(ops_fir1), .ops_fir2_o(ops_fir2), .ops_fir3_o(ops_fir3),
    .ops_issue_o(ops_issue), .ops_result_i(ops_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
    .out_result_o(out_result), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    ops_out_meta_t    res;
    int               cedge;
  } pend_t;

  pend_t pend_q[$];   // issued, result not yet captured (cedge = capture edge)
  pend_t out_q[$];    // captured, not yet consumed
  int    cyc;         // index of the next rising edge
  bit    in_rst;
  bit    last_acc;
  bit    obs_acc;
  int    n_total;
  int    n_pass;

  function automatic int lat_of(input operation_e op);
    case (op)
      OP_ADD, OP_SUB: return 1;
      OP_MUL:         return 2;
      OP_FMA:         return 3;
      default:        return 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (edge %0d)", name, obs, exp, cyc);
  endtask

  // One clock: check outputs against the model, take the edge, then drive the ops result due next.
  task automatic cycle();
    bit            exp_rdy, exp_vld, acc, pop, used;
    int            lat, outstanding;
    ops_out_meta_t res_new;
    #1;
    lat = lat_of(in_op);
    used = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].cedge == cyc + lat) used = 1'b1;
    outstanding = pend_q.size() + out_q.size();
    exp_rdy = !in_rst && !used && (outstanding < int'(OUT_DEPTH));
    exp_vld = !in_rst && (out_q.size() != 0);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("ops_issue", 64'(ops_issue), 64'(exp_rdy & in_valid));
    check("out_valid", 64'(out_valid), 64'(exp_vld));
    if (exp_vld) begin
      check("out_tag", 64'(out_tag), 64'(out_q[0].tag));
      check("out_result", 64'(out_result), 64'(out_q[0].res));
    end
    check("busy", 64'(busy), 64'(!in_rst && (outstanding != 0)));
    check("ops_op", 64'(ops_op), 64'(in_op));
    check("ops_fir", 64'({ops_fir1, ops_fir3}), 64'({fir1, fir3}));
    check("ops_fir2", 64'(ops_fir2), 64'(fir2));
    obs_acc  = in_ready & in_valid;
    acc      = exp_rdy & in_valid;
    pop      = exp_vld & out_ready;
    last_acc = acc;
    res_new  = RES_W'({$urandom(), $urandom()});
    @(posedge clk);
    if (pop) void'(out_q.pop_front());
    for (int i = 0; i < pend_q.size(); i++) begin
      if (pend_q[i].cedge == cyc) begin
        out_q.push_back(pend_q[i]);
        pend_q.delete(i);
        break;
      end
    end
    if (acc) pend_q.push_back('{tag: in_tag, res: res_new, cedge: cyc + lat});
    cyc++;
    #1;
    ops_result = RES_W'({$urandom(), $urandom()});
    foreach (pend_q[i]) if (pend_q[i].cedge == cyc) ops_result = pend_q[i].res;
    @(negedge clk);
  endtask

  task automatic rand_firs();
    fir1 = FIR_W'($urandom());
    fir2 = FIR_W'($urandom());
    fir3 = FIR_W'($urandom());
  endtask

  task automatic send(input operation_e op, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    rand_firs();
    last_acc = 1'b0;
    for (int i = 0; i < 40 && !last_acc; i++) cycle();
    in_valid = 1'b0;
    check("send_accepted", 64'(last_acc), 64'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_op = operation_e'(3'($urandom_range(0, 4)));
      rand_firs();
      cycle();
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 40 && (pend_q.size() + out_q.size()) != 0; i++) cycle();
    check("drained", 64'(pend_q.size() + out_q.size()), 64'(0));
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n  = 1'b0;
    in_rst = 1'b1;
    pend_q.delete();
    out_q.delete();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    repeat (2) cycle();
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  initial begin
    int n_acc;
    logic [TAG_W-1:0] t;
    n_total = 0; n_pass = 0; cyc = 0; last_acc = 1'b0; obs_acc = 1'b0;
    rst_n = 1'b0; in_rst = 1'b1;
    in_valid = 1'b1; in_op = OP_ADD; in_tag = '0; out_ready = 1'b1;
    rand_firs();
    ops_result = RES_W'({$urandom(), $urandom()});
    @(negedge clk);
    do_reset();

    // 1: single ADD returns its tag two cycles later.
    send(OP_ADD, 4'd3);
    idle(4);

    // 2: DIV then ADD aimed at the same completion slot; ADD must slip one cycle.
    send(OP_DIV, 4'd1);
    idle(2);
    send(OP_ADD, 4'd2);
    idle(4);

    // 3: MUL followed immediately by ADD.
    send(OP_MUL, 4'd5);
    send(OP_ADD, 4'd6);
    idle(4);

    // 4: blocked consumer, stream 8 ADDs: only OUT_DEPTH accepted, then release.
    out_ready = 1'b0;
    n_acc = 0;
    t = 4'd0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = OP_ADD; in_tag = t; rand_firs();
      cycle();
      n_acc += int'(obs_acc);
      if (last_acc) t = t + 4'd1;
    end
    check("t4_accepted", 64'(n_acc), 64'(OUT_DEPTH));
    drain();
    send(OP_SUB, 4'd9);
    drain();

    // 5: nearly full FIFO with pop and capture on the same edge.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_ADD, TAG_W'(8 + i));
    out_ready = 1'b1;
    idle(1);
    drain();

    // 6: reset with ops in flight, then no stale results.
    out_ready = 1'b0;
    send(OP_DIV, 4'd1);
    send(OP_FMA, 4'd2);
    send(OP_MUL, 4'd3);
    do_reset();
    out_ready = 1'b1;
    idle(10);

    // Random traffic with consumer stalls and one mid-run reset.
    for (int i = 0; i < 900; i++) begin
      if (i == 450) do_reset();
      in_valid = ($urandom_range(0, 9) < 7);
      in_op    = operation_e'(3'($urandom_range(0, 4)));
      in_tag   = TAG_W'($urandom());
      rand_firs();
      if ((i / 40) % 3 == 2) out_ready = ($urandom_range(0, 9) < 2);
      else                   out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
